inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch (IF) stage of the MIPS 5-stage pipeline. It keeps the fetch PC and issues word reads to instruction memory through a req/ack handshake that allows variable latency. Returned words go into a 2-entry prefetch buffer, which presents `{inst, inst_pc}` to ID, where the pipeline controller decodes them. The block obeys the controller's `if_en`/`if_rst` stage controls and takes PC redirects from jump/branch resolution.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset or `if_rst`
- `clk` input 1, main clock, rising edge
- `rst` input 1, asynchronous, active-low reset
- `if_en` input 1, stage enable; the head word is consumed when `inst_valid && if_en`
- `if_rst` input 1, synchronous stage flush back to `RESET_PC`
- `redirect` input 1, one-cycle PC redirect request (jump/branch/JR taken)
- `redirect_pc` input 32, redirect target
- `imem_req` output 1, read request
- `imem_addr` output 32, word address of the request
- `imem_ack` input 1, read data valid; may arrive in the same cycle as `imem_req`
- `imem_data` input 32, read data
- `inst` output 32, head instruction
- `inst_pc` output 32, PC of `inst`
- `inst_valid` output 1, buffer head is valid
- `fetch_err` output 1, sticky misaligned-redirect flag (only with the macro)

## Operation
- Registered state: `fetch_pc`, FSM `{IDLE, WAIT, DROP}`, 2-entry FIFO of `{pc, inst}`, `count` in 0..2.
- Request rule: `imem_req = (state==IDLE && count<2) || state==WAIT`. `imem_addr = fetch_pc`.
- IDLE:
  - With a request and ack in the same cycle: push `{fetch_pc, imem_data}`, `fetch_pc += 4`, stay in IDLE.
  - With a request and no ack: go to WAIT.
- WAIT: `imem_req` and `imem_addr` are held stable. On ack: push, `fetch_pc += 4`, go to IDLE.
- DROP: a stale request is outstanding and `imem_req` stays high. On ack the data is discarded and the FSM goes to IDLE.
- Pop: FIFO head retires on `inst_valid && if_en`. Push and pop in the same cycle leaves `count` unchanged. Push never happens when `count==2`, because no request is issued then.
- `if_en=0` holds the outputs. Prefetch continues until the FIFO is full.
- Redirect (`redirect=1`), with priority over push and pop:
  - FIFO is flushed (`count=0`) and `fetch_pc <= redirect_pc`.
  - From WAIT with no ack in that cycle: go to DROP.
  - From WAIT or IDLE with an ack in that cycle: the ack data is discarded and the FSM goes to IDLE.
  - From DROP: stay in DROP, with `fetch_pc` updated.
- `if_rst`: same as a redirect to `RESET_PC`. It also clears `fetch_err`. If `if_rst` and `redirect` occur together, `if_rst` wins.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC + 4` wraps to `0`.

## Timing
- Reset values: `fetch_pc=RESET_PC`, state IDLE, `count=0`, `inst_valid=0`, `inst=0`, `inst_pc=0`, `fetch_err=0`. `imem_req=1` in the first cycle after `rst` deasserts.
- Latency: data acked at edge N is visible with `inst_valid=1` after edge N (registered output).
- Throughput: 1 word per cycle with a zero-wait memory while ID consumes every cycle.
- First valid word after a redirect: 1 cycle after the redirect edge plus memory latency. If a request was outstanding at the redirect, add the time until its ack.
- Asynchronous reset mid-transaction abandons the request. The memory must tolerate a dropped `imem_req`.

## Configuration
- `INST_FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]!=0` sets `fetch_err`, flushes the FIFO and stops issuing requests. Any outstanding ack is still absorbed via DROP.
  - Fetching resumes only after `if_rst` or a new aligned redirect; `fetch_err` stays set until `if_rst`.
- Undefined: `redirect_pc[1:0]` is forced to 0 and `fetch_err` is tied to 0.

## Structure
- Shared package `mips_define` holds the FSM state encoding, `RESET_PC` default and `PC_STEP=4`.
- Sub-module `fetch_fifo`: a 2-entry, 64-bit-wide synchronous FIFO with push, pop, flush and count.

## Test plan
- Reset, zero-wait memory, `if_en=1` → `imem_addr` sequence 0,4,8,…. `inst_pc` runs 0,4,8 on consecutive cycles with `inst_valid` continuously 1 from the second cycle.
- Memory with 3-cycle ack latency → `imem_addr` is held for 3 cycles. `inst_valid` pulses one cycle in every 3, and `inst_pc` increments by 4.
- `if_en=0` for 5 cycles → `count` saturates at 2 and `imem_req` goes low. On release, `inst_pc` resumes with no PC skipped or duplicated.
- `redirect` to 32'h0000_0100 while in WAIT → FSM enters DROP and the pending ack data is discarded. The next valid output is `inst_pc=0x100` with the data returned for 0x100.
- `redirect` and `imem_ack` in the same cycle → the acked word never appears on `inst`, and the next request is at `redirect_pc`.
- With `INST_FETCH_ALIGN_CHECK_EN`, redirect to 0x102 → `fetch_err=1`, `imem_req=0`. Then `if_rst` → `fetch_err=0` and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared MIPS pipeline definitions used by the fetch stage:
// FSM state encoding, default reset PC, PC increment and the FIFO entry layout.
package mips_define;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // One prefetch buffer entry: PC in the upper half, instruction in the lower
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory read port: the request side is driven by the fetch stage,
// the acknowledge and data side by the memory.
interface inst_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: 2-entry prefetch buffer of {pc, inst} with push, pop, flush and
// occupancy count. The head entry is presented directly from the storage regs.
module fetch_fifo
    import mips_define::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         push_ok;
    logic         pop_ok;

    // Flush dominates; a full buffer never accepts, an empty one never retires
    assign push_ok = push && !flush && (count_reg != 2'd2);
    assign pop_ok  = pop  && !flush && (count_reg != 2'd0);

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        // Capture the pushed word into the slot the write pointer selects
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mem_reg[gi] <= '0;
            end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: MIPS IF stage. Keeps the fetch PC, issues word reads over a
// req/ack port with variable latency, buffers returned words in a 2-entry
// prefetch FIFO and handles redirects and stage flushes.
// Optional feature macro: INST_FETCH_ALIGN_CHECK_EN (misaligned redirect
// raises sticky fetch_err and halts fetching).
module inst_fetch
    import mips_define::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_en,
    input  logic              if_rst,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    inst_fetch_if.master      imem,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    output logic              fetch_err
);

    logic [31:0]  fetch_pc_reg, fetch_pc_next;
    logic [1:0]   state_reg, state_next;
    logic [1:0]   count;
    logic         flush;
    logic         push;
    logic         pop;
    logic         halt;
    logic         misaligned;
    logic [31:0]  target_pc;
    fetch_entry_t head;

    assign flush = if_rst || redirect;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic halt_reg;
    logic err_reg;

    assign misaligned = redirect && !if_rst && (redirect_pc[1:0] != 2'b00);
    assign target_pc  = if_rst ? RESET_PC : redirect_pc;

    // Misaligned target: raise the sticky error and stop requesting until
    // a stage flush or a fresh aligned redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else if (if_rst) begin
            halt_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else if (misaligned) begin
            halt_reg <= 1'b1;
            err_reg  <= 1'b1;
        end else if (redirect) begin
            halt_reg <= 1'b0;
        end
    end

    assign halt      = halt_reg;
    assign fetch_err = err_reg;
`else
    logic unused_align_bits;

    assign misaligned        = 1'b0;
    assign target_pc         = if_rst ? RESET_PC : {redirect_pc[31:2], 2'b00};
    assign unused_align_bits = ^{redirect_pc[1:0], misaligned};
    assign halt              = 1'b0;
    assign fetch_err         = 1'b0;
`endif

    // DROP keeps the stale request alive until the memory answers it
    assign imem.req  = (!halt && (((state_reg == ST_IDLE) && (count != 2'd2)) ||
                                  (state_reg == ST_WAIT))) ||
                       (state_reg == ST_DROP);
    assign imem.addr = fetch_pc_reg;

    assign push = imem.req && imem.ack && (state_reg != ST_DROP) && !flush;
    assign pop  = inst_valid && if_en && !flush;

    // Next-state and next-PC selection; flushes override push and pop
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (flush) begin
            fetch_pc_next = target_pc;
            // Any request presented but not yet answered must be absorbed
            state_next    = (imem.req && !imem.ack) ? ST_DROP : ST_IDLE;
        end else begin
            if (push) fetch_pc_next = fetch_pc_reg + PC_STEP;
            case (state_reg)
                ST_IDLE: if (imem.req && !imem.ack) state_next = ST_WAIT;
                ST_WAIT: if (imem.ack) state_next = ST_IDLE;
                ST_DROP: if (imem.ack) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Fetch PC and FSM registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg <= RESET_PC;
            state_reg    <= ST_IDLE;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            state_reg    <= state_next;
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({fetch_pc_reg, imem.data}),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count)
    );

    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign inst_valid = (count != 2'd0);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a variable-latency memory responder plus
// a reference model of the consumed instruction stream (contiguous PCs from
// the last redirect target, each paired with the memory word at that PC).
module tb_inst_fetch;
    import mips_define::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_en = 1'b0;
    logic        if_rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst, inst_pc;
    logic        inst_valid, fetch_err;

    inst_fetch_if imem ();

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .if_en       (if_en),
        .if_rst      (if_rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .fetch_err   (fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- memory responder ----------------
    int          min_lat = 0;
    int          max_lat = 0;
    bit          mem_busy = 0;
    int          mem_remain = 0;
    logic [31:0] mem_lat_addr = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    bit          flush_at_edge = 0;

    always @(posedge clk) flush_at_edge = redirect | if_rst;

    initial begin
        imem.ack  = 1'b0;
        imem.data = 32'h0;
    end

    always @(negedge clk) begin
        if (imem.ack) mem_busy = 0;
        imem.ack  = 1'b0;
        imem.data = $urandom;
        if (!rst) begin
            mem_busy = 0;
        end else begin
            if (mem_busy) begin
                chk("req_held", imem.req, 1'b1);
                if (!flush_at_edge) chk("addr_held", imem.addr, prev_addr);
            end
            if (imem.req) begin
                if (!mem_busy) begin
                    mem_busy     = 1;
                    mem_lat_addr = imem.addr;
                    mem_remain   = $urandom_range(max_lat, min_lat);
                end
                if (mem_remain == 0) begin
                    imem.ack  = 1'b1;
                    imem.data = mem_word(mem_lat_addr);
                end else begin
                    mem_remain--;
                end
            end
        end
        prev_addr = imem.addr;
    end

    // ---------------- stream reference model ----------------
    logic [31:0] exp_pc = RESET_PC_DEFAULT;
    int          n_consumed = 0;

    task automatic cycle(input bit en, input bit rd, input logic [31:0] rpc, input bit ir);
        @(negedge clk);
        if_en = en; redirect = rd; redirect_pc = rpc; if_rst = ir;
`ifndef INST_FETCH_ALIGN_CHECK_EN
        chk("fetch_err_tied", fetch_err, 1'b0);
`endif
        if (ir) begin
            exp_pc = RESET_PC_DEFAULT;
        end else if (rd) begin
            exp_pc = {rpc[31:2], 2'b00};
        end else if (inst_valid && en) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end
    endtask

    initial begin
        bit found;
        int c0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_err", fetch_err, 1'b0);
        chk("rst_req", imem.req, 1'b1);
        chk("rst_addr", imem.addr, RESET_PC_DEFAULT);
        @(posedge clk);
        #2 rst = 1'b1;

        // Zero-wait memory, full throughput
        min_lat = 0; max_lat = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 32'h0, 0);
            chk("seq_addr", imem.addr, 32'(4 * i));
            if (i > 0) chk("tput_valid", inst_valid, 1'b1);
        end

        // Stall: buffer fills, requests stop
        for (int i = 0; i < 5; i++) cycle(0, 0, 32'h0, 0);
        chk("stall_req", imem.req, 1'b0);
        chk("stall_valid", inst_valid, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 32'h0, 0);

        // Redirect while a request is pending (WAIT -> DROP)
        min_lat = 3; max_lat = 3;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 32'h0, 0);
            #1;
            if (mem_busy && mem_remain >= 1) begin
                found = 1;
                break;
            end
        end
        chk("wait_found", 32'(found), 32'd1);
        cycle(1, 1, 32'h0000_0100, 0);
        cycle(1, 0, 32'h0, 0);
        chk("drop_req", imem.req, 1'b1);
        chk("drop_addr", imem.addr, 32'h0000_0100);
        for (int i = 0; i < 20; i++) cycle(1, 0, 32'h0, 0);
        chk("drop_progress", 32'(exp_pc > 32'h0000_0100), 32'd1);

        // Redirect coinciding with an ack
        min_lat = 0; max_lat = 0;
        for (int i = 0; i < 6; i++) cycle(1, 0, 32'h0, 0);
        cycle(1, 1, 32'h0000_0300, 0);
        #1 chk("same_cycle_ack", imem.ack, 1'b1);
        cycle(1, 0, 32'h0, 0);
        chk("same_cycle_next_addr", imem.addr, 32'h0000_0300);
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 0);

        // Misaligned redirect
        cycle(1, 1, 32'h0000_0102, 0);
`ifdef INST_FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 0);
        chk("align_err", fetch_err, 1'b1);
        chk("align_req", imem.req, 1'b0);
        chk("align_valid", inst_valid, 1'b0);
        cycle(1, 0, 32'h0, 1);
        cycle(1, 0, 32'h0, 0);
        chk("align_clear", fetch_err, 1'b0);
        chk("align_restart", imem.addr, RESET_PC_DEFAULT);
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 0);
`else
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 0);
        chk("align_forced", 32'(exp_pc > 32'h0000_0100), 32'd1);
`endif

        // PC wrap at the top of the address space
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 0);
        cycle(1, 1, 32'hFFFF_FFF8, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 32'h0, 0);
        chk("wrap_pc", exp_pc, 32'h0000_000C);

        // Randomized traffic: latency, stalls, redirects and flushes
        min_lat = 0; max_lat = 3;
        c0 = n_consumed;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            bit          rd, ir;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
            rd  = ($urandom_range(0, 19) == 0);
            ir  = ($urandom_range(0, 49) == 0);
            cycle($urandom_range(0, 3) != 0, rd, rpc, ir);
        end
        cycle(1, 0, 32'h0, 0);
        chk("random_liveness", 32'(n_consumed - c0 >= 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
